flash_read_controller: RTL and testbench
========================================

# flash_read_controller

Avalon-MM read master between the audio address generator and the on-board flash controller. It accepts a one-word read request (level `start_flash` plus word address) and performs exactly one single-beat flash read. It returns the 32-bit word with a one-cycle `end_flash` completion pulse, which the address generator uses to leave its flash-read state and unpack samples.

## Interface
- `ADDR_W`, 23, word address width
- `TIMEOUT_CYCLES`, 255, cycles in ISSUE+WAIT_VALID before forced completion; used only when `FLASH_RD_TIMEOUT_EN` is defined
- `inclk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start_flash`  in  1  read request, level; held high until `end_flash` is seen
- `req_address`  in  ADDR_W  word address; sampled when a request is accepted
- `end_flash`  out  1  one-cycle completion pulse
- `read_data`  out  32  captured word; valid while `end_flash` is high and held until the next capture
- `timeout_err`  out  1  sticky timeout flag
- `flash_mem_read`  out  1  Avalon read
- `flash_mem_address`  out  ADDR_W  Avalon address
- `flash_mem_byteenable`  out  4  constant 4'b1111
- `flash_mem_burstcount`  out  6  constant 6'd1
- `flash_mem_waitrequest`  in  1  slave stall
- `flash_mem_readdatavalid`  in  1  read data strobe
- `flash_mem_readdata`  in  32  read data

## Operation
- The design is a single clock domain, and the block has five states: IDLE, ISSUE, WAIT_VALID, DONE, REARM.
- IDLE:
  - If `start_flash` is high, capture `req_address` into `flash_mem_address` and go to ISSUE.
  - `readdatavalid` is ignored in IDLE.
- ISSUE:
  - `flash_mem_read` is high and the address is held stable.
  - If `waitrequest` is high, stay in ISSUE.
  - If `waitrequest` is low and `readdatavalid` is high in the same cycle, capture the data and go to DONE.
  - If `waitrequest` is low and `readdatavalid` is low, go to WAIT_VALID.
- WAIT_VALID:
  - `flash_mem_read` is low.
  - On `readdatavalid`, capture `flash_mem_readdata` into `read_data` and go to DONE.
- DONE:
  - `end_flash` is high for exactly this one cycle.
  - Next state is REARM.
- REARM:
  - Stay in REARM while `start_flash` is high; return to IDLE when it is low.
  - This guarantees one read per request: a still-high `start_flash` is never re-accepted.
- If `start_flash` drops mid-transaction, the transaction still completes and `end_flash` still pulses; the bus cannot abort.
- `readdatavalid` outside ISSUE/WAIT_VALID is ignored and `read_data` is unchanged.
- Outputs are registered or state-decoded, with no combinational path from bus inputs to outputs.
- Reset values:
  - state IDLE
  - `end_flash`, `flash_mem_read`, `timeout_err` = 0
  - `read_data` = 0
  - `flash_mem_address` = 0
  - `byteenable` = 4'b1111
  - `burstcount` = 1
- Reset mid-transaction returns the block to IDLE immediately. Data returned by the flash after reset is dropped, and the interrupted request is not retried.

## Timing
- Edge 0 samples `start_flash` high in IDLE. `flash_mem_read` and the address are valid from cycle 1.
- Cycle 1 with `waitrequest` low: `flash_mem_read` is high for exactly one cycle.
- Each stall cycle extends `read` by one cycle; the address stays constant.
- Read latency L means `readdatavalid` arrives in cycle 1+L. `end_flash` is high in cycle 2+L and `read_data` is valid in that same cycle.
- Minimum latency, with `readdatavalid` in cycle 1: `end_flash` in cycle 2.
- The earliest next acceptance is the first IDLE cycle after `start_flash` is seen low.

## Configuration
- `FLASH_RD_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to ISSUE and increments every cycle in ISSUE/WAIT_VALID.
  - When the counter reaches `TIMEOUT_CYCLES`, the block forces DONE, deasserts `read`, sets `read_data` = 0 and sets `timeout_err` = 1.
  - `timeout_err` stays set until reset.
  - A late `readdatavalid` after a timeout is ignored.
- `FLASH_RD_TIMEOUT_EN` undefined:
  - No counter; the block waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Zero stall, `req_address`=0x00010, `readdatavalid` 2 cycles after issue with data 32'hA1B2C3D4 -> `flash_mem_read` high for 1 cycle, address 0x00010, one `end_flash` pulse in cycle 4, `read_data`=32'hA1B2C3D4.
- `waitrequest` high for 5 cycles -> `read` high for 6 cycles, address constant, exactly one accepted read, one `end_flash`.
- `start_flash` held high for 10 cycles past `end_flash` -> no second `flash_mem_read`; a new request after `start_flash` goes low for 1 cycle is accepted normally.
- Timeout with macro on, `TIMEOUT_CYCLES`=16, `readdatavalid` never asserted -> `end_flash` 16 cycles after issue, `read_data`=0, `timeout_err`=1 and staying set. With macro off -> no `end_flash` within 1000 cycles, `timeout_err`=0.
- `reset` pulsed in WAIT_VALID, then `readdatavalid` with 32'hDEADBEEF -> all outputs return to reset values, no `end_flash`, `read_data` stays 0.
- `readdatavalid` pulse with 32'h12345678 while in IDLE -> `read_data` and `end_flash` unchanged.

Source files
------------

// File: rtl/flash_read_controller.sv
// Purpose  : single-beat Avalon-MM read master; one flash word per start_flash request.
// Latency  : read issued 1 cycle after acceptance; end_flash 1 cycle after readdatavalid.
// Backpress: waitrequest holds the read and address; start_flash held high is never re-accepted.
//
// Ports:
//   inclk, reset              clock, asynchronous active-high reset
//   start_flash, req_address  level request and word address (sampled on acceptance)
//   end_flash, read_data      one-cycle completion pulse and captured word
//   timeout_err               sticky timeout flag (tied low without FLASH_RD_TIMEOUT_EN)
//   flash_mem_*               Avalon-MM read master port to the flash controller
//
// Optional feature: define FLASH_RD_TIMEOUT_EN to force completion after TIMEOUT_CYCLES
// cycles in ISSUE/WAIT_VALID, returning zero data and setting timeout_err.
module flash_read_controller #(
    parameter int ADDR_W         = 23,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              inclk,
    input  logic              reset,
    input  logic              start_flash,
    input  logic [ADDR_W-1:0] req_address,
    output logic              end_flash,
    output logic [31:0]       read_data,
    output logic              timeout_err,
    output logic              flash_mem_read,
    output logic [ADDR_W-1:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    output logic [5:0]        flash_mem_burstcount,
    input  logic              flash_mem_waitrequest,
    input  logic              flash_mem_readdatavalid,
    input  logic [31:0]       flash_mem_readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_VALID,
        S_DONE,
        S_REARM
    } state_t;

    state_t state, state_nxt;
    logic   capture_data;   // take flash_mem_readdata into read_data this cycle
    logic   force_timeout;  // abandon the read this cycle
    logic   tmo_hit;

    assign flash_mem_byteenable = 4'b1111;
    assign flash_mem_burstcount = 6'd1;

    // State-decoded outputs: no combinational path from the bus inputs.
    assign flash_mem_read = (state == S_ISSUE);
    assign end_flash      = (state == S_DONE);

`ifdef FLASH_RD_TIMEOUT_EN
    localparam int CNT_W = 16;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_err_q;

    // ISSUE is only entered from IDLE, so clearing outside ISSUE/WAIT_VALID
    // is the same as clearing on entry to ISSUE.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE || state == S_WAIT_VALID) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Decision is made in the last counted cycle so DONE lands exactly
    // TIMEOUT_CYCLES cycles after the first ISSUE cycle.
    assign tmo_hit = (state == S_ISSUE || state == S_WAIT_VALID) &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            tmo_err_q <= 1'b0;
        end else if (force_timeout) begin
            tmo_err_q <= 1'b1;
        end
    end
    assign timeout_err = tmo_err_q;
`else
    // Never true: without the timeout the read waits indefinitely.
    assign tmo_hit     = (TIMEOUT_CYCLES < 0);
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        capture_data  = 1'b0;
        force_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_flash) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Data arriving in the accept cycle wins over a coincident timeout.
                if (!flash_mem_waitrequest && flash_mem_readdatavalid) begin
                    capture_data = 1'b1;
                    state_nxt    = S_DONE;
                end else if (tmo_hit) begin
                    force_timeout = 1'b1;
                    state_nxt     = S_DONE;
                end else if (!flash_mem_waitrequest) begin
                    state_nxt = S_WAIT_VALID;
                end
            end
            S_WAIT_VALID: begin
                if (flash_mem_readdatavalid) begin
                    capture_data = 1'b1;
                    state_nxt    = S_DONE;
                end else if (tmo_hit) begin
                    force_timeout = 1'b1;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_REARM;
            end
            S_REARM: begin
                // Wait for the request level to drop so one request yields one read.
                if (!start_flash) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            flash_mem_address <= '0;
        end else if (state == S_IDLE && start_flash) begin
            flash_mem_address <= req_address;
        end
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            read_data <= '0;
        end else if (capture_data) begin
            read_data <= flash_mem_readdata;
        end else if (force_timeout) begin
            read_data <= '0;
        end
    end

endmodule

// File: tb/tb_flash_read_controller.sv
// Purpose  : directed self-checking bench for flash_read_controller.
// Latency  : cycle 1 is the first cycle after the edge that samples start_flash.
// Backpress: waitrequest and readdatavalid are driven per cycle from each vector.
module tb_flash_read_controller;

    localparam int ADDR_W = 23;

    logic              inclk;
    logic              reset;
    logic              start_flash;
    logic [ADDR_W-1:0] req_address;
    logic              end_flash;
    logic [31:0]       read_data;
    logic              timeout_err;
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [3:0]        flash_mem_byteenable;
    logic [5:0]        flash_mem_burstcount;
    logic              flash_mem_waitrequest;
    logic              flash_mem_readdatavalid;
    logic [31:0]       flash_mem_readdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-transaction observations.
    int          n_rd;
    int          n_end;
    int          end_cyc;
    int          addr_bad;
    logic [31:0] end_dat;

    flash_read_controller #(
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .inclk                  (inclk),
        .reset                  (reset),
        .start_flash            (start_flash),
        .req_address            (req_address),
        .end_flash              (end_flash),
        .read_data              (read_data),
        .timeout_err            (timeout_err),
        .flash_mem_read         (flash_mem_read),
        .flash_mem_address      (flash_mem_address),
        .flash_mem_byteenable   (flash_mem_byteenable),
        .flash_mem_burstcount   (flash_mem_burstcount),
        .flash_mem_waitrequest  (flash_mem_waitrequest),
        .flash_mem_readdatavalid(flash_mem_readdatavalid),
        .flash_mem_readdata     (flash_mem_readdata)
    );

    initial begin
        inclk = 1'b0;
        forever #5 inclk = ~inclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge inclk);
        @(negedge inclk);
    endtask

    // Raises start_flash at the current negedge (edge 0 follows), then for
    // cycles 1..ncyc observes outputs and drives the bus for that cycle.
    // waitrequest is high for cycles 1..stall; readdatavalid pulses in cycle
    // stall+1+lat; start_flash drops in cycle drop_at.
    task automatic run_txn(input logic [ADDR_W-1:0] addr, input int stall, input int lat,
                           input logic [31:0] data, input int ncyc, input int drop_at);
        req_address             = addr;
        start_flash             = 1'b1;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
        n_rd     = 0;
        n_end    = 0;
        end_cyc  = -1;
        addr_bad = 0;
        end_dat  = 32'h0;
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (flash_mem_read) begin
                n_rd++;
                if (flash_mem_address !== addr) addr_bad++;
            end
            if (end_flash) begin
                n_end++;
                end_cyc = c;
                end_dat = read_data;
            end
            flash_mem_waitrequest   = (c <= stall);
            flash_mem_readdatavalid = (c == stall + 1 + lat);
            flash_mem_readdata      = (c == stall + 1 + lat) ? data : 32'h0;
            if (c == drop_at) start_flash = 1'b0;
        end
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
    endtask

    initial begin
        reset                   = 1'b1;
        start_flash             = 1'b0;
        req_address             = '0;
        flash_mem_waitrequest   = 1'b0;
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
        step();
        step();

        // Reset state
        check("rst_end_flash", end_flash, 0);
        check("rst_read", flash_mem_read, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_read_data", read_data, 0);
        check("rst_address", flash_mem_address, 0);
        check("rst_byteenable", flash_mem_byteenable, 4'hF);
        check("rst_burstcount", flash_mem_burstcount, 1);
        reset = 1'b0;
        step();

        // Zero stall, latency 2: end_flash in cycle 4
        run_txn(23'h00010, 0, 2, 32'hA1B2C3D4, 8, 4);
        check("t1_read_cycles", n_rd, 1);
        check("t1_addr_stable", addr_bad, 0);
        check("t1_end_count", n_end, 1);
        check("t1_end_cycle", end_cyc, 4);
        check("t1_end_data", end_dat, 32'hA1B2C3D4);
        check("t1_data_held", read_data, 32'hA1B2C3D4);

        // Five stall cycles: read high 6 cycles, accept in 6, valid in 7, end in 8
        run_txn(23'h2ABCD, 5, 1, 32'h0BADF00D, 12, 8);
        check("t2_read_cycles", n_rd, 6);
        check("t2_addr_stable", addr_bad, 0);
        check("t2_end_count", n_end, 1);
        check("t2_end_cycle", end_cyc, 8);
        check("t2_end_data", end_dat, 32'h0BADF00D);

        // Minimum latency at the top address: end_flash in cycle 2
        run_txn(23'h7FFFFF, 0, 0, 32'hFFFF0001, 6, 2);
        check("t3_read_cycles", n_rd, 1);
        check("t3_addr_stable", addr_bad, 0);
        check("t3_end_cycle", end_cyc, 2);
        check("t3_end_data", end_dat, 32'hFFFF0001);

        // start_flash held 10 cycles past end_flash (cycle 2): still one read
        run_txn(23'h00123, 0, 0, 32'h11112222, 13, 12);
        check("t4_read_cycles", n_rd, 1);
        check("t4_end_count", n_end, 1);
        // start_flash was low for one cycle: the next request is accepted normally
        run_txn(23'h00456, 0, 3, 32'hCAFE0123, 8, 5);
        check("t4b_read_cycles", n_rd, 1);
        check("t4b_addr_stable", addr_bad, 0);
        check("t4b_end_cycle", end_cyc, 5);
        check("t4b_end_data", end_dat, 32'hCAFE0123);

`ifdef FLASH_RD_TIMEOUT_EN
        // No readdatavalid: forced completion 16 cycles after issue
        run_txn(23'h00777, 0, 100000, 32'h0, 20, 17);
        check("t5_read_cycles", n_rd, 1);
        check("t5_end_count", n_end, 1);
        check("t5_end_cycle", end_cyc, 17);
        check("t5_end_data", end_dat, 0);
        check("t5_timeout_err", timeout_err, 1);
        // Late readdatavalid is ignored and the flag stays set
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h77777777;
        step();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
        n_end = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (end_flash) n_end++;
        end
        check("t5_late_no_end", n_end, 0);
        check("t5_late_data", read_data, 0);
        check("t5_timeout_sticky", timeout_err, 1);
`else
        // No readdatavalid and no timeout: waits indefinitely
        run_txn(23'h00777, 0, 100000, 32'h0, 1000, 0);
        check("t5_no_end_1000", n_end, 0);
        check("t5_read_cycles", n_rd, 1);
        check("t5_timeout_err", timeout_err, 0);
`endif

        // Reset pulsed in WAIT_VALID, then data returns: dropped
        req_address = 23'h00055;
        start_flash = 1'b1;
        step();                 // cycle 1: ISSUE, accepted (waitrequest low)
        step();                 // cycle 2: WAIT_VALID
        reset       = 1'b1;
        start_flash = 1'b0;
        step();
        reset                   = 1'b0;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'hDEADBEEF;
        step();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
        n_end = 0;
        n_rd  = 0;
        for (int i = 0; i < 4; i++) begin
            if (end_flash) n_end++;
            if (flash_mem_read) n_rd++;
            step();
        end
        check("t6_no_end", n_end, 0);
        check("t6_no_read", n_rd, 0);
        check("t6_read_data", read_data, 0);
        check("t6_address", flash_mem_address, 0);
        check("t6_timeout_err", timeout_err, 0);

        // readdatavalid in IDLE leaves read_data and end_flash alone
        run_txn(23'h0003C, 0, 1, 32'h5A5A5A5A, 6, 3);
        check("t7_setup_data", read_data, 32'h5A5A5A5A);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = 32'h12345678;
        step();
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'h0;
        n_end = 0;
        for (int i = 0; i < 3; i++) begin
            if (end_flash) n_end++;
            step();
        end
        check("t7_idle_no_end", n_end, 0);
        check("t7_idle_data", read_data, 32'h5A5A5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
